// File: rtl/tod_pkg.sv
// Shared constants and BCD helpers for the time-of-day clock.
package tod_pkg;

   localparam logic [7:0] HOURS_RST = 8'h12;
   localparam logic [7:0] MIN_RST   = 8'h00;
   localparam logic [7:0] SEC_RST   = 8'h00;

   localparam logic [7:0] MIN_MAX   = 8'h59;
   localparam logic [7:0] HOUR_MAX  = 8'h12;
   localparam logic [7:0] HOUR_MIN  = 8'h01;

   // True when both digits are decimal and the value lies in [lo, hi].
   // Packed BCD with decimal digits orders the same as plain binary,
   // so the range test can compare the raw bytes.
   function automatic logic bcd_valid(input logic [7:0] value,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
      logic ok;
      ok = (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) &&
           (value >= lo) && (value <= hi);
      return ok;
   endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit packed-BCD counter that wraps from MAX to 00. Load has priority
// over increment; wrap flags the increment that rolls MAX over to 00.
module bcd_counter_2d
   import tod_pkg::*;
#(
   parameter logic [7:0] MAX     = 8'h59,
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       wrap
);

   logic [7:0] value_next;

   // Carry out to the next stage happens only on a real increment at MAX.
   assign wrap = inc && !load && (value == MAX);

   // Next-value selection: load, BCD increment with digit carry, or hold.
   always_comb begin
      value_next = value;
      if (load) begin
         value_next = load_val;
      end else if (inc) begin
         if (value == MAX) begin
            value_next = 8'h00;
         end else if (value[3:0] == 4'h9) begin
            value_next = {value[7:4] + 4'h1, 4'h0};
         end else begin
            value_next = {value[7:4], value[3:0] + 4'h1};
         end
      end else begin
         value_next = value;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= RST_VAL;
      end else begin
         value <= value_next;
      end
   end

endmodule

// File: rtl/tod_clock_bcd.sv
// 12-hour BCD time-of-day clock with a 1 Hz prescaler and validated load port.
module tod_clock_bcd
   import tod_pkg::*;
#(
   parameter int CLK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       set_en,
   input  logic [7:0] set_hours,
   input  logic [7:0] set_minutes,
   input  logic       set_pm,
   output logic [7:0] hours,
   output logic [7:0] minutes,
   output logic [7:0] seconds,
   output logic       pm,
   output logic       sec_tick,
   output logic       min_tick,
   output logic       set_err
);

   localparam int             CW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);

   logic [CW-1:0] presc;
   logic          advance;
   logic          set_ok;
   logic          set_bad;
   logic          sec_inc;
   logic          sec_wrap;
   logic          min_wrap;
   logic [7:0]    hours_next;
   logic          pm_next;

   assign advance = run && (presc == CNT_MAX);
   assign set_ok  = set_en && bcd_valid(set_hours, HOUR_MIN, HOUR_MAX)
                           && bcd_valid(set_minutes, 8'h00, MIN_MAX);
   assign set_bad = set_en && !set_ok;
   // Any load attempt, accepted or not, swallows a coincident advance.
   assign sec_inc = advance && !set_en;

   bcd_counter_2d #(.MAX(MIN_MAX), .RST_VAL(SEC_RST)) u_seconds (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (sec_inc),
      .load     (set_ok),
      .load_val (8'h00),
      .value    (seconds),
      .wrap     (sec_wrap)
   );

   bcd_counter_2d #(.MAX(MIN_MAX), .RST_VAL(MIN_RST)) u_minutes (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (sec_wrap),
      .load     (set_ok),
      .load_val (set_minutes),
      .value    (minutes),
      .wrap     (min_wrap)
   );

   // Prescaler: cleared by a valid load, otherwise free-runs while run is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (set_ok) begin
         presc <= '0;
      end else if (run) begin
         presc <= (presc == CNT_MAX) ? '0 : presc + CNT_ONE;
      end
   end

   // Hour stepping: 09->10, 12->01, otherwise bump the low digit; 11->12 flips pm.
   always_comb begin
      hours_next = hours;
      pm_next    = pm;
      if (set_ok) begin
         hours_next = set_hours;
         pm_next    = set_pm;
      end else if (min_wrap) begin
         case (hours)
            8'h09:   hours_next = 8'h10;
            8'h12:   hours_next = HOUR_MIN;
            8'h11: begin
               hours_next = HOUR_MAX;
               pm_next    = !pm;
            end
            default: hours_next = {hours[7:4], hours[3:0] + 4'h1};
         endcase
      end else begin
         hours_next = hours;
         pm_next    = pm;
      end
   end

   // Hours/pm registers and the one-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hours    <= HOURS_RST;
         pm       <= 1'b0;
         sec_tick <= 1'b0;
         min_tick <= 1'b0;
         set_err  <= 1'b0;
      end else begin
         hours    <= hours_next;
         pm       <= pm_next;
         sec_tick <= sec_inc;
         min_tick <= sec_wrap;
         set_err  <= set_bad;
      end
   end

endmodule
